// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: address split, frame layout, fill FSM states.
// The ICACHE_PERF_EN macro, when defined, adds hit/miss counters to icache_direct.
package cpu_types_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 32 - 2 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        FETCH
    } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Storage for the direct-mapped frames: combinational read port, synchronous write port,
// valid bits cleared synchronously on reset (tag/data are left uninitialised).
module icache_frame_array #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 32 - 2 - IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rIdx_i,
    output logic             rValid_o,
    output logic [TAG_W-1:0] rTag_o,
    output logic [31:0]      rData_o,
    input  logic             wEn_i,
    input  logic [IDX_W-1:0] wIdx_i,
    input  logic [TAG_W-1:0] wTag_i,
    input  logic [31:0]      wData_i
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (wEn_i) begin
            valid_q[wIdx_i] <= 1'b1;
        end
    end

    // Reset has priority so a fill that coincides with reset leaves no trace.
    always_ff @(posedge clk_i) begin
        if (wEn_i && !rst_i) begin
            tag_q[wIdx_i]  <= wTag_i;
            data_q[wIdx_i] <= wData_i;
        end
    end

    assign rValid_o = valid_q[rIdx_i];
    assign rTag_o   = tag_q[rIdx_i];
    assign rData_o  = data_q[rIdx_i];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with a single-word fill FSM.
// Defining ICACHE_PERF_EN adds saturating hit_count/miss_count outputs.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - 2 - IDX_W;

    icache_state_t state_q;
    logic [31:0]   maddr_q;

    logic             frameValid;
    logic [TAG_W-1:0] frameTag;
    logic [31:0]      frameData;
    logic             hitRaw;
    logic             fillEn;

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) frames (
        .clk_i    (CLK),
        .rst_i    (RST),
        .rIdx_i   (imemaddr[2+IDX_W-1:2]),
        .rValid_o (frameValid),
        .rTag_o   (frameTag),
        .rData_o  (frameData),
        .wEn_i    (fillEn),
        .wIdx_i   (maddr_q[2+IDX_W-1:2]),
        .wTag_i   (maddr_q[31:2+IDX_W]),
        .wData_i  (iload)
    );

    assign hitRaw = (state_q == IDLE) && imemREN && frameValid
                    && (frameTag == imemaddr[31:2+IDX_W]);

    // Outputs are forced quiet while reset is held, whatever state we were in.
    assign ihit     = hitRaw && !RST;
    assign imemload = ihit ? frameData : '0;
    assign iREN     = (state_q == FETCH) && !RST;
    assign iaddr    = iREN ? maddr_q : '0;
    assign fillEn   = (state_q == FETCH) && !iwait && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            maddr_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (imemREN && !hitRaw) begin
                        maddr_q <= imemaddr;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    logic        lastHit_q;
    logic [29:0] lastAddr_q;
    logic [31:0] hitCount_q;
    logic [31:0] missCount_q;
    logic        newFetchHit;

    // A stalled fetch keeps presenting the same address; count it only once.
    assign newFetchHit = ihit && !(lastHit_q && (lastAddr_q == imemaddr[31:2]));

    always_ff @(posedge CLK) begin
        if (RST) begin
            lastHit_q   <= 1'b0;
            lastAddr_q  <= '0;
            hitCount_q  <= '0;
            missCount_q <= '0;
        end else begin
            lastHit_q  <= ihit;
            lastAddr_q <= imemaddr[31:2];
            if (newFetchHit && (hitCount_q != '1)) begin
                hitCount_q <= hitCount_q + 32'd1;
            end
            if ((state_q == IDLE) && imemREN && !hitRaw && (missCount_q != '1)) begin
                missCount_q <= missCount_q + 32'd1;
            end
        end
    end

    assign hit_count  = hitCount_q;
    assign miss_count = missCount_q;
`endif

endmodule
